c3po_gen2: RTL and testbench

C3PO_GEN2 -- requirements
Module: c3po_gen2

---
 rtl/c3po_gen2_pkg.sv | 23 ++
 rtl/c3po_gen2_slice.sv | 154 +++++++++++++++
 rtl/c3po_gen2.sv | 133 +++++++++++++
 tb/tb_c3po_gen2.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3po_gen2_pkg.sv
// Shared types and constants for the c3po_gen2 beat unpacker.
package c3po_gen2_pkg;

  // Per-port packet control state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  // Register map base addresses; the port index is added to the base.
  localparam logic [7:0] ADDR_CFG  = 8'h00;
  localparam logic [7:0] ADDR_CNT0 = 8'h10;
  localparam logic [7:0] ADDR_CNT1 = 8'h20;
  localparam logic [7:0] ADDR_STAT = 8'h30;

  // Field offsets inside the cfg and status registers.
  localparam int CFG_ID_LSB    = 0;
  localparam int CFG_ID_W      = 4;
  localparam int CFG_EN_BIT    = 4;
  localparam int STAT_ERR_BIT  = 0;
  localparam int STAT_IDLE_BIT = 1;

endpackage

// File: rtl/c3po_gen2_slice.sv
// One output port: packet FSM, beat-to-chunk unpacker and statistics counters.
module c3po_gen2_slice
  import c3po_gen2_pkg::*;
#(
  parameter int IN_BYTES_P  = 160,
  parameter int OUT_BYTES_P = 32,
  parameter int CNT_SIZE_P  = 8,
  parameter int SAT_P       = 0
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [3:0]                cfg_id_i,
  input  logic                      cfg_en_i,
  input  logic                      val_i,
  input  logic                      sop_i,
  input  logic                      eop_i,
  input  logic [3:0]                id_i,
  input  logic [7:0]                vbc_i,
  input  logic [IN_BYTES_P*8-1:0]   data_i,
  input  logic                      clr_cnt0_i,
  input  logic                      clr_cnt1_i,
  input  logic                      clr_err_i,
  output logic                      ready_o,
  output logic                      o_val_o,
  output logic                      o_sop_o,
  output logic                      o_eop_o,
  output logic [7:0]                o_vbc_o,
  output logic [OUT_BYTES_P*8-1:0]  o_data_o,
  output logic                      idle_o,
  output logic                      error_o,
  output logic [CNT_SIZE_P-1:0]     cnt0_o,
  output logic [CNT_SIZE_P-1:0]     cnt1_o
);

  localparam int         IW      = IN_BYTES_P * 8;
  localparam int         OW      = OUT_BYTES_P * 8;
  localparam logic [7:0] IN_B    = 8'(IN_BYTES_P);
  localparam logic [7:0] OUT_B   = 8'(OUT_BYTES_P);
  localparam logic [32:0] CNT_MAX = 33'({32{1'b1}} >> (32 - CNT_SIZE_P));

  state_e                state_q, state_d;
  logic                  en_q, en_eff;
  logic [IW-1:0]         buf_q, buf_d, mask;
  logic [7:0]            rem_q, rem_d, vbc_eff, chunk_b;
  logic                  first_q, first_d, eop_q, eop_d;
  logic                  acc, over, drop, load;
  logic [CNT_SIZE_P-1:0] cnt0_q, cnt1_q, cnt0_nx, cnt1_nx;
  logic [32:0]           sum0, sum1;
  logic                  err_q;

  // Enable follows config directly while idle, frozen while a packet is open.
  assign en_eff  = (state_q == ST_IDLE) ? cfg_en_i : en_q;
  // Ready once at most the chunk currently on the output remains.
  assign ready_o = (rem_q <= OUT_B);
  assign acc     = val_i && (id_i == cfg_id_i) && en_eff && ready_o;
  assign over    = (vbc_i > IN_B);
  assign vbc_eff = over ? IN_B : vbc_i;
  assign drop    = (vbc_i == 8'd0) || ((state_q == ST_IDLE) && !sop_i) ||
                   ((state_q == ST_PKT) && sop_i);
  assign load    = acc && !drop;

  assign chunk_b  = (rem_q > OUT_B) ? OUT_B : rem_q;
  assign o_val_o  = (rem_q != 8'd0);
  assign o_sop_o  = o_val_o && first_q;
  assign o_eop_o  = o_val_o && eop_q && (rem_q <= OUT_B);
  assign o_vbc_o  = chunk_b;
  assign o_data_o = o_val_o ? buf_q[OW-1:0] : '0;
  assign idle_o   = !o_val_o && (state_q == ST_IDLE);
  assign error_o  = err_q;
  assign cnt0_o   = cnt0_q;
  assign cnt1_o   = cnt1_q;

  // Byte mask so bytes beyond the valid count enter the buffer as zero.
  always_comb begin
    mask = '0;
    for (int b = 0; b < IN_BYTES_P; b++)
      if (8'(b) < vbc_eff) mask[b*8 +: 8] = 8'hFF;
  end

  // Packet FSM next state; a stray sop inside a packet aborts back to idle.
  always_comb begin
    state_d = state_q;
    if (acc) begin
      case (state_q)
        ST_IDLE: if (load && sop_i && !eop_i) state_d = ST_PKT;
        ST_PKT:  if (sop_i || (load && eop_i)) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Unpacker: shift out one chunk per cycle, reload on an accepted beat.
  always_comb begin
    buf_d   = buf_q;
    rem_d   = rem_q;
    first_d = first_q;
    eop_d   = eop_q;
    if (o_val_o) begin
      buf_d   = buf_q >> OW;
      rem_d   = rem_q - chunk_b;
      first_d = 1'b0;
    end
    if (load) begin
      buf_d   = data_i & mask;
      rem_d   = vbc_eff;
      first_d = sop_i;
      eop_d   = eop_i;
    end
  end

  // Counter next values, wrapping or saturating.
  always_comb begin
    sum0    = 33'(cnt0_q) + 33'd1;
    sum1    = 33'(cnt1_q) + 33'(vbc_eff);
    cnt0_nx = (SAT_P != 0 && sum0 > CNT_MAX) ? CNT_SIZE_P'(CNT_MAX) : CNT_SIZE_P'(sum0);
    cnt1_nx = (SAT_P != 0 && sum1 > CNT_MAX) ? CNT_SIZE_P'(CNT_MAX) : CNT_SIZE_P'(sum1);
  end

  // Control state and unpacker registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      buf_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_eff;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      eop_q   <= eop_d;
    end
  end

  // Statistics and sticky error; register clears win over updates.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (clr_cnt0_i)          cnt0_q <= '0;
      else if (acc && eop_i)   cnt0_q <= cnt0_nx;
      if (clr_cnt1_i)          cnt1_q <= '0;
      else if (load)           cnt1_q <= cnt1_nx;
      if (clr_err_i)           err_q  <= 1'b0;
      else if (acc && (drop || over)) err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/c3po_gen2.sv
// Multi-port beat unpacker: per-port slices plus a shared register block.
module c3po_gen2
  import c3po_gen2_pkg::*;
#(
  parameter int PORTS_P     = 4,
  parameter int IN_BYTES_P  = 160,
  parameter int OUT_BYTES_P = 32,
  parameter int CNT_SIZE_P  = 8,
  parameter int SAT_P       = 0
) (
  input  logic                              clk,
  input  logic                              reset_L,
  input  logic                              val,
  input  logic                              sop,
  input  logic                              eop,
  input  logic [3:0]                        id,
  input  logic [7:0]                        vbc,
  input  logic [IN_BYTES_P*8-1:0]           data,
  output logic [PORTS_P-1:0]                ready,
  output logic [PORTS_P-1:0]                o_val,
  output logic [PORTS_P-1:0]                o_sop,
  output logic [PORTS_P-1:0]                o_eop,
  output logic [PORTS_P*8-1:0]              o_vbc,
  output logic [PORTS_P*OUT_BYTES_P*8-1:0]  o_data,
  output logic [PORTS_P-1:0]                idle,
  output logic [PORTS_P-1:0]                error,
  input  logic                              req,
  input  logic                              rd_wr,
  input  logic [7:0]                        addr,
  input  logic [31:0]                       write_val,
  output logic                              ack,
  output logic [31:0]                       read_val
);

  localparam int OW = OUT_BYTES_P * 8;

  logic [PORTS_P-1:0][3:0]            cfg_id_q;
  logic [PORTS_P-1:0]                 cfg_en_q;
  logic [PORTS_P-1:0][CNT_SIZE_P-1:0] cnt0_w, cnt1_w;
  logic [PORTS_P-1:0]                 clr_cnt0, clr_cnt1, clr_err;
  logic                               wr_en, ack_q;
  logic [31:0]                        rdata, read_val_q;
  logic                               unused_wv;

  assign wr_en     = req && rd_wr;
  assign unused_wv = ^write_val[31:5];

  for (genvar i = 0; i < PORTS_P; i++) begin : g_slice
    assign clr_cnt0[i] = wr_en && (addr == ADDR_CNT0 + 8'(i));
    assign clr_cnt1[i] = wr_en && (addr == ADDR_CNT1 + 8'(i));
    assign clr_err[i]  = wr_en && (addr == ADDR_STAT + 8'(i)) && write_val[STAT_ERR_BIT];

    c3po_gen2_slice #(
      .IN_BYTES_P (IN_BYTES_P),
      .OUT_BYTES_P(OUT_BYTES_P),
      .CNT_SIZE_P (CNT_SIZE_P),
      .SAT_P      (SAT_P)
    ) u_slice (
      .clk       (clk),
      .reset_L   (reset_L),
      .cfg_id_i  (cfg_id_q[i]),
      .cfg_en_i  (cfg_en_q[i]),
      .val_i     (val),
      .sop_i     (sop),
      .eop_i     (eop),
      .id_i      (id),
      .vbc_i     (vbc),
      .data_i    (data),
      .clr_cnt0_i(clr_cnt0[i]),
      .clr_cnt1_i(clr_cnt1[i]),
      .clr_err_i (clr_err[i]),
      .ready_o   (ready[i]),
      .o_val_o   (o_val[i]),
      .o_sop_o   (o_sop[i]),
      .o_eop_o   (o_eop[i]),
      .o_vbc_o   (o_vbc[i*8 +: 8]),
      .o_data_o  (o_data[i*OW +: OW]),
      .idle_o    (idle[i]),
      .error_o   (error[i]),
      .cnt0_o    (cnt0_w[i]),
      .cnt1_o    (cnt1_w[i])
    );
  end

  // Per-port config registers; port i comes out of reset listening on id i.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < PORTS_P; i++) begin
        cfg_id_q[i] <= 4'(i);
        cfg_en_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < PORTS_P; i++) begin
        if (addr == ADDR_CFG + 8'(i)) begin
          cfg_id_q[i] <= write_val[CFG_ID_LSB +: CFG_ID_W];
          cfg_en_q[i] <= write_val[CFG_EN_BIT];
        end
      end
    end
  end

  // Read mux; unmapped addresses read zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < PORTS_P; i++) begin
      if (addr == ADDR_CFG + 8'(i)) begin
        rdata[CFG_ID_LSB +: CFG_ID_W] = cfg_id_q[i];
        rdata[CFG_EN_BIT]             = cfg_en_q[i];
      end
      if (addr == ADDR_CNT0 + 8'(i)) rdata = 32'(cnt0_w[i]);
      if (addr == ADDR_CNT1 + 8'(i)) rdata = 32'(cnt1_w[i]);
      if (addr == ADDR_STAT + 8'(i)) begin
        rdata[STAT_IDLE_BIT] = idle[i];
        rdata[STAT_ERR_BIT]  = error[i];
      end
    end
  end

  // Single-cycle ack the cycle after req; read data only qualified by ack.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ack_q      <= 1'b0;
      read_val_q <= '0;
    end else begin
      ack_q      <= req;
      read_val_q <= (req && !rd_wr) ? rdata : '0;
    end
  end

  assign ack      = ack_q;
  assign read_val = read_val_q;

endmodule

// File: tb/tb_c3po_gen2.sv
// Scoreboard bench for c3po_gen2: wrapping DUT plus a saturating twin on the same inputs.
module tb_c3po_gen2;
  localparam int P  = 4;
  localparam int IB = 160;
  localparam int OB = 32;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  logic val = 0, sop = 0, eop = 0, req = 0, rd_wr = 0;
  logic [3:0] id = '0;
  logic [7:0] vbc = '0, addr = '0;
  logic [IB*8-1:0] data = '0;
  logic [31:0] write_val = '0;

  logic [P-1:0] ready, o_val, o_sop, o_eop, idle, error;
  logic [P*8-1:0] o_vbc;
  logic [P*OB*8-1:0] o_data;
  logic ack;
  logic [31:0] read_val;
  logic [P-1:0] s_ready, s_o_val, s_o_sop, s_o_eop, s_idle, s_error;
  logic [P*8-1:0] s_o_vbc;
  logic [P*OB*8-1:0] s_o_data;
  logic s_ack;
  logic [31:0] s_read_val;

  c3po_gen2 #(.PORTS_P(P), .IN_BYTES_P(IB), .OUT_BYTES_P(OB), .CNT_SIZE_P(8), .SAT_P(0)) dut (
    .clk(clk), .reset_L(reset_L), .val(val), .sop(sop), .eop(eop), .id(id), .vbc(vbc),
    .data(data), .ready(ready), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_vbc(o_vbc),
    .o_data(o_data), .idle(idle), .error(error), .req(req), .rd_wr(rd_wr), .addr(addr),
    .write_val(write_val), .ack(ack), .read_val(read_val));

  c3po_gen2 #(.PORTS_P(P), .IN_BYTES_P(IB), .OUT_BYTES_P(OB), .CNT_SIZE_P(8), .SAT_P(1)) dut_s (
    .clk(clk), .reset_L(reset_L), .val(val), .sop(sop), .eop(eop), .id(id), .vbc(vbc),
    .data(data), .ready(s_ready), .o_val(s_o_val), .o_sop(s_o_sop), .o_eop(s_o_eop),
    .o_vbc(s_o_vbc), .o_data(s_o_data), .idle(s_idle), .error(s_error), .req(req),
    .rd_wr(rd_wr), .addr(addr), .write_val(write_val), .ack(s_ack), .read_val(s_read_val));

  typedef struct {
    logic sop;
    logic eop;
    logic [7:0] vbc;
    logic [OB*8-1:0] data;
  } chunk_t;

  chunk_t expq[P][$];
  logic [31:0] rdq[$];
  logic [31:0] rdsq[$];
  int checks = 0;
  int fails = 0;
  int last_wait;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Input payload: byte k carries (seed+k), including bytes past vbc.
  function automatic logic [IB*8-1:0] mkdata(input int seed);
    logic [IB*8-1:0] d;
    for (int k = 0; k < IB; k++) d[k*8 +: 8] = 8'(seed + k);
    return d;
  endfunction

  // Expected chunks of an n-byte beat, at most upto of them.
  task automatic push_beat(input int p, input bit s, input bit e, input int n, input int seed,
                           input int upto = 99);
    int nch = (n + OB - 1) / OB;
    for (int c = 0; c < nch && c < upto; c++) begin
      chunk_t ch;
      int nb = (n - c*OB > OB) ? OB : n - c*OB;
      ch.sop = s && (c == 0);
      ch.eop = e && (c == nch - 1);
      ch.vbc = 8'(nb);
      ch.data = '0;
      for (int k = 0; k < nb; k++) ch.data[k*8 +: 8] = 8'(seed + c*OB + k);
      expq[p].push_back(ch);
    end
  endtask

  // Present a beat to id p; holds it until ready[p] and one edge past that.
  task automatic beat(input int p, input bit s, input bit e, input int n, input int seed);
    val = 1; sop = s; eop = e; id = 4'(p); vbc = 8'(n); data = mkdata(seed);
    last_wait = 0;
    while (!ready[p] && last_wait < 50) begin
      @(posedge clk); #1; last_wait++;
    end
    if (last_wait >= 50) begin
      checks++; fails++;
      $display("FAIL ready_timeout port=%0d waited=%0d", p, last_wait);
    end
    @(posedge clk); #1;
    val = 0; sop = 0; eop = 0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e0, input logic [31:0] e1);
    req = 1; rd_wr = 0; addr = a;
    rdq.push_back(e0); rdsq.push_back(e1);
    @(posedge clk); #1;
    req = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    req = 1; rd_wr = 1; addr = a; write_val = v;
    rdq.push_back(32'h0); rdsq.push_back(32'h0);
    @(posedge clk); #1;
    req = 0; rd_wr = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: pops expected chunks and register responses as the DUT presents them.
  always @(negedge clk) begin
    chunk_t c;
    logic [31:0] e;
    for (int p = 0; p < P; p++) begin
      if (o_val[p]) begin
        if (expq[p].size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_chunk port=%0d vbc=%0d expected=none", p, o_vbc[p*8 +: 8]);
        end else begin
          c = expq[p].pop_front();
          chk($sformatf("p%0d_sop", p), 256'(o_sop[p]), 256'(c.sop));
          chk($sformatf("p%0d_eop", p), 256'(o_eop[p]), 256'(c.eop));
          chk($sformatf("p%0d_vbc", p), 256'(o_vbc[p*8 +: 8]), 256'(c.vbc));
          chk($sformatf("p%0d_data", p), o_data[p*OB*8 +: OB*8], c.data);
        end
      end
    end
    if (ack) begin
      if (rdq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_ack read_val=%0h expected=none", read_val);
      end else begin
        e = rdq.pop_front();
        chk("read_val", 256'(read_val), 256'(e));
      end
    end else chk("read_val_noack", 256'(read_val), 256'(0));
    if (s_ack) begin
      if (rdsq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_ack_sat read_val=%0h expected=none", s_read_val);
      end else begin
        e = rdsq.pop_front();
        chk("read_val_sat", 256'(s_read_val), 256'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end

  initial begin
    // Reset values
    cyc(3);
    chk("rst_ready", 256'(ready), 256'(4'hF));
    chk("rst_idle", 256'(idle), 256'(4'hF));
    chk("rst_o_val", 256'(o_val), 256'(0));
    chk("rst_error", 256'(error), 256'(0));
    chk("rst_o_data", 256'(o_data[255:0]), 256'(0));
    chk("rst_ack", 256'(ack), 256'(0));
    reset_L = 1;
    cyc(1);

    // Config defaults, unmapped address, enables
    rd(8'h02, 32'h02, 32'h02);
    rd(8'h10, 32'h0, 32'h0);
    wr(8'h40, 32'hFF);
    rd(8'h40, 32'h0, 32'h0);
    wr(8'h00, 32'h10);
    wr(8'h01, 32'h11);
    wr(8'h02, 32'h12);
    rd(8'h00, 32'h10, 32'h10);

    // 100-byte single-beat packet -> 32,32,32,4
    push_beat(0, 1, 1, 100, 17);
    beat(0, 1, 1, 100, 17);
    chk("first_chunk_N+1", 256'(o_val[0]), 256'(1));
    chk("ready_N+1", 256'(ready[0]), 256'(0));
    cyc(1); chk("ready_N+2", 256'(ready[0]), 256'(0));
    cyc(1); chk("ready_N+3", 256'(ready[0]), 256'(0));
    cyc(1); chk("ready_N+4", 256'(ready[0]), 256'(1));

    // Back-to-back 32-byte beats, no stall
    wr(8'h10, 32'h0);
    wr(8'h20, 32'h0);
    push_beat(0, 1, 0, 32, 40);
    beat(0, 1, 0, 32, 40);
    chk("b2b_wait1", 256'(last_wait), 256'(0));
    push_beat(0, 0, 1, 32, 90);
    beat(0, 0, 1, 32, 90);
    chk("b2b_wait2", 256'(last_wait), 256'(0));
    chk("b2b_ready", 256'(ready[0]), 256'(1));
    rd(8'h10, 32'd1, 32'd1);
    rd(8'h20, 32'd64, 32'd64);

    // vbc==0 is dropped with error; status write clears it
    beat(0, 1, 1, 0, 0);
    chk("vbc0_error", 256'(error[0]), 256'(1));
    wr(8'h30, 32'h1);
    chk("vbc0_err_clr", 256'(error[0]), 256'(0));

    // vbc=200 is clamped to 160 (five full chunks) and flags error
    push_beat(0, 1, 1, 160, 5);
    beat(0, 1, 1, 200, 5);
    chk("clamp_error", 256'(error[0]), 256'(1));
    cyc(6);
    wr(8'h30, 32'h1);

    // Non-sop beat to idle port1: dropped; status shows idle and error bits
    beat(1, 0, 0, 20, 3);
    chk("nosop_error", 256'(error[1]), 256'(1));
    rd(8'h31, 32'h3, 32'h3);
    wr(8'h31, 32'h1);
    chk("nosop_err_clr", 256'(error[1]), 256'(0));
    rd(8'h31, 32'h2, 32'h2);

    // Disable port2 mid-packet: packet finishes, next sop ignored
    push_beat(2, 1, 0, 32, 50);
    beat(2, 1, 0, 32, 50);
    wr(8'h02, 32'h02);
    push_beat(2, 0, 0, 40, 60);
    beat(2, 0, 0, 40, 60);
    push_beat(2, 0, 1, 10, 70);
    beat(2, 0, 1, 10, 70);
    beat(2, 1, 1, 16, 80);
    cyc(4);
    chk("dis_idle2", 256'(idle[2]), 256'(1));
    rd(8'h12, 32'd1, 32'd1);
    rd(8'h22, 32'd82, 32'd82);

    // Nine 32-byte beats: wrap gives 288-256=32, saturate gives 255
    wr(8'h20, 32'h0);
    for (int i = 0; i < 9; i++) begin
      push_beat(0, 1, 1, 32, 8*i);
      beat(0, 1, 1, 32, 8*i);
    end
    rd(8'h20, 32'd32, 32'd255);
    cyc(3);

    // Reset during the third chunk of a 160-byte beat
    push_beat(0, 1, 1, 160, 100, 2);
    beat(0, 1, 1, 160, 100);
    cyc(2);
    reset_L = 0;
    #1;
    chk("rst_mid_o_val", 256'(o_val), 256'(0));
    chk("rst_mid_o_data", 256'(o_data[255:0]), 256'(0));
    chk("rst_mid_o_vbc", 256'(o_vbc), 256'(0));
    chk("rst_mid_idle", 256'(idle), 256'(4'hF));
    chk("rst_mid_ready", 256'(ready), 256'(4'hF));
    cyc(3);
    reset_L = 1;
    cyc(8);
    chk("post_rst_o_val", 256'(o_val), 256'(0));
    rd(8'h00, 32'h0, 32'h0);
    rd(8'h20, 32'h0, 32'h0);
    cyc(4);

    for (int p = 0; p < P; p++) chk($sformatf("drain_p%0d", p), 256'(expq[p].size()), 256'(0));
    chk("drain_rd", 256'(rdq.size()), 256'(0));
    chk("drain_rd_sat", 256'(rdsq.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
